// File: rtl/code_queue.sv
// rtl/code_queue.sv - byte-granular code queue: word fetch in, variable-length consume out.
// Storage is one packed byte vector; bytes at or above the count are kept zero.
module code_queue #(
  parameter int FETCH_BYTES = 4,
  parameter int DEPTH_BYTES = 32,
  parameter int WIN_BYTES   = 16,
  parameter int IP_W        = 32,
  localparam int LEN_W = $clog2(WIN_BYTES + 1),
  localparam int CNT_W = $clog2(DEPTH_BYTES + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic [IP_W-1:0]          i_flush_ip,
  input  logic                     i_fetch_valid,
  input  logic [FETCH_BYTES*8-1:0] i_fetch_data,
  output logic                     o_fetch_ready,
  input  logic                     i_consume_valid,
  input  logic [LEN_W-1:0]         i_consume_len,
  output logic [WIN_BYTES*8-1:0]   o_window,
  output logic [CNT_W-1:0]         o_count,
  output logic                     o_win_full,
  output logic [IP_W-1:0]          o_ip,
  output logic                     o_err
);

  localparam int SKW = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
  localparam int DW  = DEPTH_BYTES * 8;
  localparam int FW  = FETCH_BYTES * 8;

  typedef enum logic {RUN, ALIGN} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IP_W-1:0]  ip_q, ip_d;
  logic [SKW-1:0]   skip_q, skip_d;
  logic             err_q, err_d;

  logic             fetch_fire, cons_ok;
  logic [CNT_W-1:0] len_ext, base, nbytes;
  logic [SKW-1:0]   sk;
  logic [FW-1:0]    aligned, fmask;
  logic [DW-1:0]    ins;

  assign len_ext       = CNT_W'(i_consume_len);
  assign o_fetch_ready = !reset && !i_flush && (count_q <= CNT_W'(DEPTH_BYTES - FETCH_BYTES));
  assign fetch_fire    = i_fetch_valid && o_fetch_ready;
  assign cons_ok       = i_consume_valid && (len_ext <= count_q);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    ip_d    = ip_q;
    skip_d  = skip_q;
    err_d   = 1'b0;
    sk      = (state_q == ALIGN) ? skip_q : '0;
    nbytes  = CNT_W'(FETCH_BYTES) - CNT_W'(sk);
    aligned = i_fetch_data >> (8 * sk);
    fmask   = '0;
    for (int j = 0; j < FETCH_BYTES; j++) begin
      if (CNT_W'(j) < nbytes) fmask[8*j +: 8] = 8'hFF;
    end
    // New bytes land just above whatever survives this cycle's consume.
    base = count_q - (cons_ok ? len_ext : '0);
    ins  = DW'(aligned & fmask) << (8 * base);

    if (i_flush) begin
      buf_d   = '0;
      count_d = '0;
      ip_d    = i_flush_ip;
      skip_d  = (FETCH_BYTES > 1) ? i_flush_ip[SKW-1:0] : '0;
      state_d = (skip_d != '0) ? ALIGN : RUN;
    end else begin
      if (cons_ok) begin
        buf_d   = buf_q >> (8 * len_ext);
        count_d = count_q - len_ext;
        ip_d    = ip_q + IP_W'(i_consume_len);
      end else if (i_consume_valid) begin
        err_d = 1'b1;
      end
      if (fetch_fire) begin
        buf_d   = buf_d | ins;
        count_d = count_d + nbytes;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      buf_q   <= '0;
      count_q <= '0;
      ip_q    <= '0;
      skip_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      ip_q    <= ip_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  assign o_window   = buf_q[WIN_BYTES*8-1:0];
  assign o_count    = count_q;
  assign o_win_full = (count_q >= CNT_W'(WIN_BYTES));
  assign o_ip       = ip_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_code_queue.sv
// tb/tb_code_queue.sv - directed and random checks of code_queue against a byte-queue model.
module tb_code_queue;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         i_flush = 1'b0;
  logic [31:0]  i_flush_ip = '0;
  logic         i_fetch_valid = 1'b0;
  logic [31:0]  i_fetch_data = '0;
  logic         o_fetch_ready;
  logic         i_consume_valid = 1'b0;
  logic [4:0]   i_consume_len = '0;
  logic [127:0] o_window;
  logic [5:0]   o_count;
  logic         o_win_full;
  logic [31:0]  o_ip;
  logic         o_err;

  code_queue dut (
    .clock(clock), .reset(reset), .i_flush(i_flush), .i_flush_ip(i_flush_ip),
    .i_fetch_valid(i_fetch_valid), .i_fetch_data(i_fetch_data), .o_fetch_ready(o_fetch_ready),
    .i_consume_valid(i_consume_valid), .i_consume_len(i_consume_len), .o_window(o_window),
    .o_count(o_count), .o_win_full(o_win_full), .o_ip(o_ip), .o_err(o_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: queued bytes oldest-first, plus IP and pending alignment.
  logic [7:0]  m_q[$];
  logic [31:0] m_ip = '0;
  int          m_skip = 0;
  bit          m_align = 1'b0;
  bit          m_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_window();
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < m_q.size()) w[8*i +: 8] = m_q[i];
    return w;
  endfunction

  task automatic step(input bit rst, input bit fl, input logic [31:0] fip, input bit fv,
                      input logic [31:0] fd, input bit cv, input int len);
    bit rdy;
    int sk;
    @(negedge clock);
    reset = rst; i_flush = fl; i_flush_ip = fip; i_fetch_valid = fv; i_fetch_data = fd;
    i_consume_valid = cv; i_consume_len = 5'(len);
    #1;
    rdy = !rst && !fl && (m_q.size() <= 28);
    chk("ready", 128'(o_fetch_ready), 128'(rdy));
    @(posedge clock);
    m_err = 1'b0;
    if (rst) begin
      m_q.delete(); m_ip = '0; m_skip = 0; m_align = 1'b0;
    end else if (fl) begin
      m_q.delete(); m_ip = fip; m_skip = fip % 4; m_align = (m_skip != 0);
    end else begin
      if (cv) begin
        if (len <= m_q.size()) begin
          repeat (len) void'(m_q.pop_front());
          m_ip = m_ip + 32'(len);
        end else m_err = 1'b1;
      end
      if (fv && rdy) begin
        sk = m_align ? m_skip : 0;
        for (int b = sk; b < 4; b++) m_q.push_back(fd[8*b +: 8]);
        m_align = 1'b0;
      end
    end
    #1;
    chk("count", 128'(o_count), 128'(m_q.size()));
    chk("window", o_window, exp_window());
    chk("ip", 128'(o_ip), 128'(m_ip));
    chk("win_full", 128'(o_win_full), 128'(m_q.size() >= 16));
    chk("err", 128'(o_err), 128'(m_err));
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    step(1, 0, '0, 0, '0, 0, 0);
    step(1, 1, 32'h55, 1, 32'hFFFFFFFF, 1, 2);
    chk("rst_count", 128'(o_count), 0);
    chk("rst_window", o_window, 0);
    chk("rst_ip", 128'(o_ip), 0);
    chk("rst_err", 128'(o_err), 0);

    // unaligned flush then one fetch
    step(0, 1, 32'h1002, 0, '0, 0, 0);
    step(0, 0, '0, 1, 32'h44332211, 0, 0);
    chk("align_count", 128'(o_count), 2);
    chk("align_window", o_window, 128'h4433);
    chk("align_ip", 128'(o_ip), 32'h1002);
    step(0, 0, '0, 1, 32'h88776655, 0, 0);
    chk("run_after_align", o_window, 128'h887766554433);

    // fill to capacity; byte k of the stream holds value k
    step(0, 1, 32'h0, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 32'h03020100 + 32'(i) * 32'h04040404, 0, 0);
    chk("full_count", 128'(o_count), 32);
    chk("full_ready", 128'(o_fetch_ready), 0);
    chk("full_win", 128'(o_win_full), 1);
    step(0, 0, '0, 1, 32'hDEADBEEF, 0, 0);
    chk("full_drop", 128'(o_count), 32);
    step(0, 0, '0, 0, '0, 1, 4);
    chk("ready_again", 128'(o_fetch_ready), 1);

    // simultaneous consume and fetch
    step(0, 0, '0, 0, '0, 1, 12);
    chk("c16_count", 128'(o_count), 16);
    step(0, 0, '0, 1, 32'hDDCCBBAA, 1, 3);
    chk("sim_count", 128'(o_count), 17);
    chk("sim_b0", 128'(o_window[7:0]), 8'h13);
    chk("sim_b13", 128'(o_window[111:104]), 8'hAA);

    // rejected over-length consume
    step(0, 1, 32'h0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 32'h12345678, 0, 0);
    step(0, 0, '0, 0, '0, 1, 1);
    step(0, 0, '0, 0, '0, 1, 5);
    chk("rej_err", 128'(o_err), 1);
    chk("rej_count", 128'(o_count), 3);
    chk("rej_ip", 128'(o_ip), 1);
    idle();
    chk("rej_pulse", 128'(o_err), 0);
    step(0, 0, '0, 0, '0, 1, 0);
    chk("len0_count", 128'(o_count), 3);

    // flush beats fetch and consume
    step(0, 1, 32'h0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 32'hA0A0A0A0 + 32'(i), 0, 0);
    chk("c12_count", 128'(o_count), 12);
    step(0, 1, 32'h2000, 1, 32'h11111111, 1, 4);
    chk("fl_count", 128'(o_count), 0);
    chk("fl_ip", 128'(o_ip), 32'h2000);
    chk("fl_err", 128'(o_err), 0);

    // IP wrap
    step(0, 1, 32'hFFFFFFFE, 0, '0, 0, 0);
    step(0, 0, '0, 1, 32'h44332211, 0, 0);
    step(0, 0, '0, 1, 32'h88776655, 0, 0);
    step(0, 0, '0, 0, '0, 1, 4);
    chk("wrap_ip", 128'(o_ip), 32'h2);
    chk("wrap_count", 128'(o_count), 2);

    // mid-stream reset discards content
    step(1, 0, '0, 1, 32'h99999999, 1, 1);
    chk("mid_rst_count", 128'(o_count), 0);

    for (int n = 0; n < 3000; n++) begin
      bit r, f, fv, cv;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 31) == 0);
      fv = ($urandom_range(0, 3) != 0);
      cv = $urandom_range(0, 1);
      step(r, f, $urandom, fv, $urandom, cv, $urandom_range(0, 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_queue.md
CODE_QUEUE -- requirements
Module: code_queue

Interface
REQ-001 Parameter FETCH_BYTES, default 4, bytes per fetch word (power of two, 1..8).
REQ-002 Parameter DEPTH_BYTES, default 32, byte storage capacity (multiple of FETCH_BYTES, >= WIN_BYTES).
REQ-003 Parameter WIN_BYTES, default 16, byte width of the decode window.
REQ-004 Parameter IP_W, default 32, instruction-pointer width.
REQ-005 clock  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 i_flush  in  1  restart stream at i_flush_ip.
REQ-008 i_flush_ip  in  IP_W  new linear IP.
REQ-009 i_fetch_valid  in  1  fetch word offered.
REQ-010 i_fetch_data  in  FETCH_BYTES*8  little-endian word; byte 0 = bits [7:0].
REQ-011 o_fetch_ready  out  1  queue accepts a word this cycle.
REQ-012 i_consume_valid  in  1  decoder retires bytes.
REQ-013 i_consume_len  in  clog2(WIN_BYTES+1)  bytes retired, 0..WIN_BYTES.
REQ-014 o_window  out  WIN_BYTES*8  oldest WIN_BYTES queued bytes, byte 0 = bits [7:0].
REQ-015 o_count  out  clog2(DEPTH_BYTES+1)  queued byte count.
REQ-016 o_win_full  out  1  o_count >= WIN_BYTES.
REQ-017 o_ip  out  IP_W  linear address of window byte 0.
REQ-018 o_err  out  1  one-cycle pulse on rejected consume.

Function
REQ-019 FSM states: RUN (append whole words), ALIGN (next accepted word has its low skip bytes discarded).
REQ-020 o_fetch_ready = (o_count <= DEPTH_BYTES - FETCH_BYTES) and not i_flush, from registered count only, independent of same-cycle consume.
REQ-021 Fetch handshake completes when i_fetch_valid and o_fetch_ready are both 1.
REQ-022 Consume accepted when i_consume_valid, not i_flush, and i_consume_len <= o_count; else, with i_consume_valid high, o_err = 1 next cycle, no state change.
REQ-023 Accepted consume: window shifts down by len bytes, o_count -= len, o_ip += len modulo 2^IP_W, all visible next cycle.
REQ-024 Simultaneous accepted consume and fetch: consume applies first; new bytes written at index o_count - len; next o_count = o_count - len + appended bytes.
REQ-025 RUN fetch appends FETCH_BYTES bytes; ALIGN fetch appends FETCH_BYTES - skip bytes (bytes skip..FETCH_BYTES-1), then FSM -> RUN.
REQ-026 Flush (highest priority): o_count -> 0, o_ip -> i_flush_ip, skip -> i_flush_ip[clog2(FETCH_BYTES)-1:0]; FSM -> ALIGN if skip != 0, else RUN; same-cycle consume ignored, no o_err.
REQ-027 Flush in ALIGN: skip is reloaded from the new i_flush_ip.
REQ-028 o_window bytes at index >= o_count read 0x00; storage beyond count is zeroed on shift.
REQ-029 o_count never exceeds DEPTH_BYTES and never underflows.
REQ-030 Consume len 0 accepted: no state change, no o_err.

Reset
REQ-031 reset overrides all inputs including i_flush.
REQ-032 Reset values: o_count 0, o_ip 0, o_window 0, o_err 0, FSM RUN, skip 0; o_fetch_ready 1 in the first cycle after reset.
REQ-033 Reset mid-stream discards all queued bytes; no handshake is completed in the reset cycle.

Verification (FETCH_BYTES=4, DEPTH_BYTES=32, WIN_BYTES=16)
REQ-034 Reset; flush ip 0x1002; fetch 0x44332211 -> o_count 2, o_window[15:0] 0x4433, rest 0, o_ip 0x1002, FSM RUN.
REQ-035 From empty, RUN state, 8 back-to-back fetches, no consume -> o_count 32, o_fetch_ready 0, o_win_full 1; consume 4 -> o_fetch_ready 1 next cycle.
REQ-036 o_count 16, same-cycle consume 3 and fetch 0xDDCCBBAA -> o_count 17, old byte 3 at window index 0, 0xAA at index 13.
REQ-037 o_count 3, consume len 5 -> o_err pulse 1 cycle, o_count 3, o_ip unchanged.
REQ-038 o_count 12, flush ip 0x2000 with fetch valid and consume 4 same cycle -> o_count 0, fetch data dropped, o_ip 0x2000, no o_err.
REQ-039 o_ip 0xFFFFFFFE, o_count >= 4, consume 4 -> o_ip 0x00000002.
